// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: one symbol (1..18) per handshake, codeword shifted out
// MSB first at one bit per clock, back-to-back codewords with no idle bit.
module huffman_encoder #(
    parameter int SYM_W   = 6,
    parameter int MAX_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             sym_last,
    output logic             sym_err,
    output logic             busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] shift_q;
    logic [3:0]         cnt_q;
    logic               bit_valid_q, sym_last_q, sym_err_q, busy_q;

    logic [MAX_LEN-1:0] code_c;
    logic [3:0]         len_c;
    logic               legal_c;
    logic               accept;

    // Codes are left-aligned so the MSB of the shift register is always the next bit.
    always_comb begin
        code_c  = '0;
        len_c   = 4'd0;
        legal_c = 1'b1;
        case (sym_in)
            SYM_W'(1):  begin code_c = MAX_LEN'(8'b0000_0000); len_c = 4'd2; end
            SYM_W'(2):  begin code_c = MAX_LEN'(8'b0100_0000); len_c = 4'd2; end
            SYM_W'(3):  begin code_c = MAX_LEN'(8'b1000_0000); len_c = 4'd2; end
            SYM_W'(4):  begin code_c = MAX_LEN'(8'b1100_0000); len_c = 4'd3; end
            SYM_W'(5):  begin code_c = MAX_LEN'(8'b1110_0000); len_c = 4'd6; end
            SYM_W'(6):  begin code_c = MAX_LEN'(8'b1110_0100); len_c = 4'd6; end
            SYM_W'(7):  begin code_c = MAX_LEN'(8'b1110_1000); len_c = 4'd6; end
            SYM_W'(8):  begin code_c = MAX_LEN'(8'b1110_1100); len_c = 4'd7; end
            SYM_W'(9):  begin code_c = MAX_LEN'(8'b1110_1110); len_c = 4'd7; end
            SYM_W'(10): begin code_c = MAX_LEN'(8'b1111_0000); len_c = 4'd7; end
            SYM_W'(11): begin code_c = MAX_LEN'(8'b1111_0010); len_c = 4'd7; end
            SYM_W'(12): begin code_c = MAX_LEN'(8'b1111_0100); len_c = 4'd7; end
            SYM_W'(13): begin code_c = MAX_LEN'(8'b1111_0110); len_c = 4'd7; end
            SYM_W'(14): begin code_c = MAX_LEN'(8'b1111_1000); len_c = 4'd7; end
            SYM_W'(15): begin code_c = MAX_LEN'(8'b1111_1010); len_c = 4'd7; end
            SYM_W'(16): begin code_c = MAX_LEN'(8'b1111_1100); len_c = 4'd7; end
            SYM_W'(17): begin code_c = MAX_LEN'(8'b1111_1110); len_c = 4'd8; end
            SYM_W'(18): begin code_c = MAX_LEN'(8'b1111_1111); len_c = 4'd8; end
            default:    legal_c = 1'b0;
        endcase
    end

    // Ready on the last bit lets the next code load on the same edge the old one ends.
    assign sym_ready = (state_q == IDLE) || (cnt_q == 4'd1);
    assign accept    = sym_valid && sym_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= 4'd0;
            bit_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            sym_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sym_err_q <= accept && !legal_c;
            if (state_q == SHIFT && cnt_q != 4'd1) begin
                shift_q    <= shift_q << 1;
                cnt_q      <= cnt_q - 4'd1;
                sym_last_q <= (cnt_q == 4'd2);
            end else if (accept && legal_c) begin
                state_q     <= SHIFT;
                shift_q     <= code_c;
                cnt_q       <= len_c;
                bit_valid_q <= 1'b1;
                busy_q      <= 1'b1;
                sym_last_q  <= 1'b0;
            end else begin
                state_q     <= IDLE;
                shift_q     <= '0;
                cnt_q       <= 4'd0;
                bit_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                sym_last_q  <= 1'b0;
            end
        end
    end

    assign bit_out   = shift_q[MAX_LEN-1];
    assign bit_valid = bit_valid_q;
    assign sym_last  = sym_last_q;
    assign sym_err   = sym_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_huffman_encoder.sv
// Bench for huffman_encoder: queue-of-bits reference model plus a string-matching
// decoder that recovers the symbol stream from bit_out.
module tb_huffman_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sym_in;
    logic       sym_valid;
    logic       sym_ready, bit_out, bit_valid, sym_last, sym_err, busy;

    int   n_chk = 0;
    int   n_err = 0;
    string codes [19];
    bit   rem [$];      // bits of the codeword still to be shown on bit_out
    logic err_exp;
    int   sent [$];
    int   dec [$];
    string dbuf;

    huffman_encoder #(.SYM_W(6), .MAX_LEN(8)) dut (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .bit_out(bit_out), .bit_valid(bit_valid),
        .sym_last(sym_last), .sym_err(sym_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predict from the spec's rules, then compare after the edge.
    task automatic step(output logic acc);
        logic m_ready;
        int   s;
        m_ready = (rem.size() <= 1);
        chk("sym_ready", sym_ready, m_ready);
        acc = sym_valid && m_ready;
        if (rem.size() > 0) void'(rem.pop_front());
        err_exp = 1'b0;
        if (acc) begin
            s = int'(sym_in);
            if (s >= 1 && s <= 18) begin
                rem = {};
                for (int i = 0; i < codes[s].len(); i++) rem.push_back(codes[s][i] == "1");
                sent.push_back(s);
            end else begin
                err_exp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("bit_valid", bit_valid, rem.size() > 0);
        chk("busy", busy, rem.size() > 0);
        chk("bit_out", bit_out, rem.size() > 0 ? rem[0] : 1'b0);
        chk("sym_last", sym_last, rem.size() == 1);
        chk("sym_err", sym_err, err_exp);
        if (bit_valid) begin
            bit hit = 1'b0;
            dbuf = {dbuf, bit_out ? "1" : "0"};
            for (int k = 1; k <= 18; k++)
                if (!hit && dbuf == codes[k]) begin
                    dec.push_back(k);
                    dbuf = "";
                    hit = 1'b1;
                end
        end
    endtask

    task automatic send(input int s);
        logic acc;
        int   budget;
        sym_in    = 6'(s);
        sym_valid = 1'b1;
        budget    = 0;
        acc       = 1'b0;
        while (!acc && budget < 20) begin
            step(acc);
            budget++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        sym_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bit_out"}, bit_out, 0);
        chk({tag, "_bit_valid"}, bit_valid, 0);
        chk({tag, "_sym_last"}, sym_last, 0);
        chk({tag, "_sym_err"}, sym_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, dec.size(), sent.size());
        for (int i = 0; i < sent.size() && i < dec.size(); i++)
            chk({tag, "_sym"}, dec[i], sent[i]);
        chk({tag, "_tail"}, dbuf.len(), 0);
        sent = {};
        dec  = {};
        dbuf = "";
    endtask

    initial begin
        codes[0]  = "";
        codes[1]  = "00";      codes[2]  = "01";      codes[3]  = "10";
        codes[4]  = "110";     codes[5]  = "111000";  codes[6]  = "111001";
        codes[7]  = "111010";  codes[8]  = "1110110"; codes[9]  = "1110111";
        codes[10] = "1111000"; codes[11] = "1111001"; codes[12] = "1111010";
        codes[13] = "1111011"; codes[14] = "1111100"; codes[15] = "1111101";
        codes[16] = "1111110"; codes[17] = "11111110"; codes[18] = "11111111";
        dbuf = "";

        rst = 1'b1; sym_in = '0; sym_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst = 1'b0;
        #1 chk("reset_ready", sym_ready, 1);

        // Shortest code, then a 3-bit code followed gaplessly by the longest one.
        send(1);  idle(3);
        send(4);  send(18); idle(10);
        check_stream("directed");

        // Illegal symbols: sym_err pulse only, no bits.
        send(0);  send(19); idle(2);
        send(63); idle(2);

        // Every mid-length code, back to back.
        for (int s = 5; s <= 16; s++) send(s);
        idle(9);
        check_stream("table");

        // Reset mid-codeword abandons the partial code.
        send(17); idle(2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        rem = {}; sent = {}; dbuf = "";
        @(negedge clk) rst = 1'b0;
        #1 chk("midrst_ready", sym_ready, 1);
        send(2); idle(4);
        check_stream("after_rst");

        // Random loopback with gaps and the occasional illegal symbol.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) send(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(19, 63));
            else send($urandom_range(1, 18));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(10);
        check_stream("loopback");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
